fp_add_pipe: RTL and testbench

//   Pipelined, parametrised IEEE-754 binary floating-point adder/subtractor with a valid/ready handshake.

---
 rtl/fp_add_pipe_if.sv | 25 ++
 rtl/fp_add_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fp_add_pipe_if.sv
// Valid/ready operand and result channels of the pipelined floating-point adder.
// The master drives operands and result acceptance; the slave is the adder.
interface fp_add_pipe_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic [3:0]   out_flags;

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-754 adder/subtractor (unpack+align, add+lzc, normalise+round+pack)
// with RNE rounding, optional flush-to-zero and per-result exception flags.
module fp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int FTZ   = 0
) (
   input logic          clk,
   input logic          rst_n,
   fp_add_pipe_if.slave bus
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int N   = MAN_W + 4;
   localparam int LZW = $clog2(N + 1);
   localparam int EW2 = EXP_W + 2;
   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
   localparam logic [EW2-1:0]   E2_ONE   = {{(EW2-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic logic [LZW-1:0] lzc_f(input logic [N-1:0] v);
      logic [LZW-1:0] n;
      n = LZW'(N);
      for (int i = 0; i < N; i++) begin
         if (v[i]) n = LZW'(N - 1 - i);
      end
      return n;
   endfunction

   logic adv_s;
   logic out_valid_q;
   logic [W-1:0] out_result_q, out_result_d;
   logic [3:0]   out_flags_q, out_flags_d;

   assign adv_s          = ~out_valid_q | bus.out_ready;
   assign bus.in_ready   = adv_s;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_flags  = out_flags_q;

   // Mantissa layout in N bits: hidden, fraction, guard, round, sticky.
   logic             sa_s, sb_s, swap_s;
   logic [EXP_W-1:0] ea_s, eb_s;
   logic [MAN_W-1:0] fa_s, fb_s;
   logic             a_nan_s, b_nan_s, a_snan_s, b_snan_s, a_inf_s, b_inf_s;

   assign sa_s     = bus.in_a[W-1];
   assign sb_s     = bus.in_b[W-1] ^ bus.in_sub;
   assign ea_s     = bus.in_a[W-2:MAN_W];
   assign eb_s     = bus.in_b[W-2:MAN_W];
   assign fa_s     = (FTZ != 0 && ea_s == {EXP_W{1'b0}}) ? {MAN_W{1'b0}} : bus.in_a[MAN_W-1:0];
   assign fb_s     = (FTZ != 0 && eb_s == {EXP_W{1'b0}}) ? {MAN_W{1'b0}} : bus.in_b[MAN_W-1:0];
   assign a_nan_s  = (ea_s == EXP_ONES) && (fa_s != {MAN_W{1'b0}});
   assign b_nan_s  = (eb_s == EXP_ONES) && (fb_s != {MAN_W{1'b0}});
   assign a_snan_s = a_nan_s & ~fa_s[MAN_W-1];
   assign b_snan_s = b_nan_s & ~fb_s[MAN_W-1];
   assign a_inf_s  = (ea_s == EXP_ONES) && (fa_s == {MAN_W{1'b0}});
   assign b_inf_s  = (eb_s == EXP_ONES) && (fb_s == {MAN_W{1'b0}});
   assign swap_s   = {eb_s, fb_s} > {ea_s, fa_s};

   logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_spec_q, s1_inv_q;
   logic             s1_sign_d, s1_sub_d, s1_spec_d, s1_inv_d;
   logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
   logic [N-1:0]     s1_mx_q, s1_mx_d, s1_my_q, s1_my_d;
   logic [W-1:0]     s1_spec_res_q, s1_spec_res_d;
   logic [EXP_W-1:0] ex_s, ey_s, ey_eff_s, diff_s;
   logic [MAN_W-1:0] fx_s, fy_s;
   logic [N-1:0]     my_s, shr_s;

   // Stage 1: order operands by magnitude, align the smaller one, classify specials.
   always_comb begin
      ex_s      = swap_s ? eb_s : ea_s;
      ey_s      = swap_s ? ea_s : eb_s;
      fx_s      = swap_s ? fb_s : fa_s;
      fy_s      = swap_s ? fa_s : fb_s;
      s1_sign_d = swap_s ? sb_s : sa_s;
      s1_sub_d  = sa_s ^ sb_s;
      s1_exp_d  = (ex_s == {EXP_W{1'b0}}) ? EXP_ONE : ex_s;
      ey_eff_s  = (ey_s == {EXP_W{1'b0}}) ? EXP_ONE : ey_s;
      diff_s    = s1_exp_d - ey_eff_s;
      s1_mx_d   = {|ex_s, fx_s, 3'b000};
      my_s      = {|ey_s, fy_s, 3'b000};
      shr_s     = my_s >> diff_s;
      if (diff_s >= EXP_W'(N - 1)) begin
         s1_my_d = {{(N-1){1'b0}}, |my_s};
      end else begin
         s1_my_d = {shr_s[N-1:1], shr_s[0] | (|(my_s & ~({N{1'b1}} << diff_s)))};
      end
      if (a_nan_s || b_nan_s) begin
         s1_spec_d = 1'b1;  s1_spec_res_d = QNAN;  s1_inv_d = a_snan_s | b_snan_s;
      end else if (a_inf_s && b_inf_s && (sa_s != sb_s)) begin
         s1_spec_d = 1'b1;  s1_spec_res_d = QNAN;  s1_inv_d = 1'b1;
      end else if (a_inf_s) begin
         s1_spec_d = 1'b1;  s1_spec_res_d = {sa_s, EXP_ONES, {MAN_W{1'b0}}};  s1_inv_d = 1'b0;
      end else if (b_inf_s) begin
         s1_spec_d = 1'b1;  s1_spec_res_d = {sb_s, EXP_ONES, {MAN_W{1'b0}}};  s1_inv_d = 1'b0;
      end else begin
         s1_spec_d = 1'b0;  s1_spec_res_d = {W{1'b0}};  s1_inv_d = 1'b0;
      end
   end

   logic             s2_valid_q, s2_sign_q, s2_sub_q, s2_spec_q, s2_inv_q;
   logic [EXP_W-1:0] s2_exp_q;
   logic [N:0]       s2_sum_q, s2_sum_d;
   logic [LZW-1:0]   s2_lzc_q, s2_lzc_d;
   logic [W-1:0]     s2_spec_res_q;

   // Stage 2: effective add/subtract with carry bit and leading-zero count.
   always_comb begin
      if (s1_sub_q) begin
         s2_sum_d = {1'b0, s1_mx_q} - {1'b0, s1_my_q};
      end else begin
         s2_sum_d = {1'b0, s1_mx_q} + {1'b0, s1_my_q};
      end
      s2_lzc_d = lzc_f(s2_sum_d[N-1:0]);
   end

   logic [EW2-1:0]   sh_s, emax_s, lzc_ext_s, norm_e_s, exp_f_s, exp_fld_s;
   logic [N-1:0]     norm_m_s;
   logic [MAN_W:0]   keep_s, mant_f_s;
   logic [MAN_W+1:0] rnd_s;
   logic             rup_s, inex_s, tiny_s;

   // Stage 3: normalise (clamped at the subnormal boundary), round RNE, pack.
   always_comb begin
      lzc_ext_s = EW2'(s2_lzc_q);
      emax_s    = {2'b00, s2_exp_q} - E2_ONE;
      sh_s      = {EW2{1'b0}};
      if (s2_sum_q[N]) begin
         norm_m_s = {s2_sum_q[N:2], s2_sum_q[1] | s2_sum_q[0]};
         norm_e_s = {2'b00, s2_exp_q} + E2_ONE;
      end else begin
         sh_s     = (lzc_ext_s > emax_s) ? emax_s : lzc_ext_s;
         norm_m_s = s2_sum_q[N-1:0] << sh_s;
         norm_e_s = {2'b00, s2_exp_q} - sh_s;
      end
      keep_s = norm_m_s[N-1:3];
      inex_s = |norm_m_s[2:0];
      rup_s  = norm_m_s[2] & (norm_m_s[1] | norm_m_s[0] | keep_s[0]);
      tiny_s = ~norm_m_s[N-1];
      rnd_s  = {1'b0, keep_s} + {{(MAN_W+1){1'b0}}, rup_s};
      if (rnd_s[MAN_W+1]) begin
         mant_f_s = rnd_s[MAN_W+1:1];
         exp_f_s  = norm_e_s + E2_ONE;
      end else begin
         mant_f_s = rnd_s[MAN_W:0];
         exp_f_s  = norm_e_s;
      end
      exp_fld_s = mant_f_s[MAN_W] ? exp_f_s : {EW2{1'b0}};
      if (s2_spec_q) begin
         out_result_d = s2_spec_res_q;
         out_flags_d  = {s2_inv_q, 3'b000};
      end else if (s2_sum_q == {(N+1){1'b0}}) begin
         out_result_d = {s2_sub_q ? 1'b0 : s2_sign_q, {(W-1){1'b0}}};
         out_flags_d  = 4'b0000;
      end else if (FTZ != 0 && tiny_s) begin
         out_result_d = {s2_sign_q, {(W-1){1'b0}}};
         out_flags_d  = 4'b0011;
      end else if (exp_fld_s >= {2'b00, EXP_ONES}) begin
         out_result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
         out_flags_d  = 4'b0101;
      end else begin
         out_result_d = {s2_sign_q, exp_fld_s[EXP_W-1:0], mant_f_s[MAN_W-1:0]};
         out_flags_d  = {2'b00, tiny_s & inex_s, inex_s};
      end
   end

   // Pipeline registers: every stage advances together or holds together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q    <= 1'b0;          s2_valid_q    <= 1'b0;
         s1_sign_q     <= 1'b0;          s2_sign_q     <= 1'b0;
         s1_sub_q      <= 1'b0;          s2_sub_q      <= 1'b0;
         s1_spec_q     <= 1'b0;          s2_spec_q     <= 1'b0;
         s1_inv_q      <= 1'b0;          s2_inv_q      <= 1'b0;
         s1_exp_q      <= {EXP_W{1'b0}}; s2_exp_q      <= {EXP_W{1'b0}};
         s1_spec_res_q <= {W{1'b0}};     s2_spec_res_q <= {W{1'b0}};
         s1_mx_q       <= {N{1'b0}};     s1_my_q       <= {N{1'b0}};
         s2_sum_q      <= {(N+1){1'b0}}; s2_lzc_q      <= {LZW{1'b0}};
         out_valid_q   <= 1'b0;
         out_result_q  <= {W{1'b0}};
         out_flags_q   <= 4'b0000;
      end else if (adv_s) begin
         s1_valid_q    <= bus.in_valid;
         s1_sign_q     <= s1_sign_d;
         s1_sub_q      <= s1_sub_d;
         s1_spec_q     <= s1_spec_d;
         s1_inv_q      <= s1_inv_d;
         s1_exp_q      <= s1_exp_d;
         s1_spec_res_q <= s1_spec_res_d;
         s1_mx_q       <= s1_mx_d;
         s1_my_q       <= s1_my_d;
         s2_valid_q    <= s1_valid_q;
         s2_sign_q     <= s1_sign_q;
         s2_sub_q      <= s1_sub_q;
         s2_spec_q     <= s1_spec_q;
         s2_inv_q      <= s1_inv_q;
         s2_exp_q      <= s1_exp_q;
         s2_spec_res_q <= s1_spec_res_q;
         s2_sum_q      <= s2_sum_d;
         s2_lzc_q      <= s2_lzc_d;
         out_valid_q   <= s2_valid_q;
         if (s2_valid_q) begin
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
         end
      end
   end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: reference vectors, RNE ties, specials, overflow,
// subnormals, flush-to-zero, back-pressure streaming and mid-flight async reset.
module tb_fp_add_pipe;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fp_add_pipe_if #(.W(32)) bus ();
   fp_add_pipe_if #(.W(32)) bus_z ();

   fp_add_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );
   fp_add_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(1)) dut_z (
      .clk(clk), .rst_n(rst_n), .bus(bus_z.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] er, input logic [3:0] ef);
      int cnt;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      cnt = 1;
      while (!bus.out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check_eq({tag, "_lat"}, 32'(cnt), 32'd3);
      check_eq({tag, "_res"}, bus.out_result, er);
      check_eq({tag, "_flg"}, 32'(bus.out_flags), 32'(ef));
   endtask

   task automatic run_z(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] er, input logic [3:0] ef);
      int cnt;
      @(negedge clk);
      bus_z.in_valid = 1'b1; bus_z.in_a = a; bus_z.in_b = b; bus_z.in_sub = sub;
      bus_z.out_ready = 1'b1;
      @(negedge clk);
      bus_z.in_valid = 1'b0;
      cnt = 1;
      while (!bus_z.out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check_eq({tag, "_lat"}, 32'(cnt), 32'd3);
      check_eq({tag, "_res"}, bus_z.out_result, er);
      check_eq({tag, "_flg"}, 32'(bus_z.out_flags), 32'(ef));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] st_a [8];
      logic [31:0] st_e [8];
      int          n_in, n_out, ca, cv, spurious;
      logic        saw_stall;

      st_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      st_e = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

      bus.in_valid = 1'b0;   bus.in_a = 32'h0;   bus.in_b = 32'h0;   bus.in_sub = 1'b0;
      bus.out_ready = 1'b1;
      bus_z.in_valid = 1'b0; bus_z.in_a = 32'h0; bus_z.in_b = 32'h0; bus_z.in_sub = 1'b0;
      bus_z.out_ready = 1'b1;

      #12;
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_out_result", bus.out_result, 32'h0);
      check_eq("rst_out_flags", 32'(bus.out_flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);

      run_op("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
      run_op("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
      run_op("rne_tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
      run_op("rne_tie_odd",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
      run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
      run_op("snan_in",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
      run_op("qnan_in",       32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
      run_op("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
      run_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
      run_op("sub_to_norm",   32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 4'b0000);
      run_op("negz_negz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
      run_op("negz_posz",     32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
      run_op("one_minus_two", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
      run_op("far_sticky",    32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0001);

      run_z("ftz_tiny_diff",  32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
      run_z("ftz_sub_input",  32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);

      // Back-to-back stream with the consumer stalled for cycles 4..8.
      n_in = 0; n_out = 0; ca = -1; cv = -1; saw_stall = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         bus.out_ready = !(c >= 4 && c <= 8);
         bus.in_valid  = (n_in < 8);
         if (n_in < 8) begin
            bus.in_a = st_a[n_in]; bus.in_b = 32'h3F800000; bus.in_sub = 1'b0;
         end
         #1;
         if (!bus.in_ready) saw_stall = 1'b1;
         if (bus.out_valid && cv < 0) cv = c;
         if (bus.in_valid && bus.in_ready) begin
            if (ca < 0) ca = c;
            n_in++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (n_out < 8) check_eq($sformatf("stream_res%0d", n_out), bus.out_result, st_e[n_out]);
            n_out++;
         end
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      check_eq("stream_count", 32'(n_out), 32'd8);
      check_eq("stream_first_lat", 32'(cv - ca), 32'd3);
      check_eq("stream_stall_seen", 32'(saw_stall), 32'd1);

      // Async reset with three operations in flight.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b1; bus.in_a = st_a[c]; bus.in_b = 32'h3F800000; bus.in_sub = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check_eq("inflight_valid", 32'(bus.out_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("async_rst_result", bus.out_result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.out_valid) spurious++;
      end
      check_eq("no_stale_result", 32'(spurious), 32'd0);
      run_op("post_reset", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
